cpu_mem_bridge: RTL
===================

Name: cpu_mem_bridge

Overview:
- Downstream of the cpu core: turns the core's memory requests (address, rw, write data) into a handshaked transaction on the external memory bus, and returns read data to the core's data input.
- Adds wait-state tolerance, a per-transaction timeout and an address-range check.
- Provides a ready/error completion pulse so the core's state sequencer can stall on slow memory instead of assuming single-cycle access.

Parameters:
- ADDR_LIMIT, 32'h0001_0000, first illegal address; any address >= ADDR_LIMIT is rejected without a bus cycle.
- TIMEOUT, 255, maximum cycles mem_req is held waiting for mem_ack (legal range 1..255).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low; sampled on the clk rising edge.
- cpu_req  input  1  one-cycle request strobe from the core.
- cpu_rw  input  1  1 = read, 0 = write.
- cpu_address  input  32  transaction address.
- cpu_datao  input  32  write data.
- cpu_data  output  32  read data returned to the core.
- cpu_ready  output  1  one-cycle completion pulse.
- cpu_err  output  1  qualifies cpu_ready: transaction failed.
- mem_req  output  1  bus request, held until acknowledged.
- mem_we  output  1  1 = write cycle.
- mem_addr  output  32  bus address.
- mem_wdata  output  32  bus write data.
- mem_ack  input  1  bus acknowledge; also means mem_rdata is valid on reads.
- mem_rdata  input  32  bus read data.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE; timeout counter = 0.
  - Outputs cpu_data, cpu_ready, cpu_err, mem_req, mem_we, mem_addr, mem_wdata all = 0.
  - Reset applied in any state aborts the transaction; mem_req is low from the following cycle.
- States: IDLE, ISSUE, RESP, ERR (2-bit encoding).
- IDLE:
  - cpu_req = 1: latch cpu_rw, cpu_address and cpu_datao.
  - If cpu_address < ADDR_LIMIT, go to ISSUE; otherwise go to ERR (no bus cycle is issued).
  - cpu_req = 0: stay in IDLE.
- ISSUE:
  - Drive mem_req = 1, mem_we = ~latched rw, mem_addr and mem_wdata from the latched values; these are stable for the whole state.
  - mem_ack = 1 at an edge: on a read, capture mem_rdata into cpu_data; go to RESP.
  - No ack: increment the counter. If the counter == TIMEOUT-1 and there is no ack, go to ERR, so mem_req is high for exactly TIMEOUT cycles.
  - Ack on the same edge as timeout expiry: ack wins and the state goes to RESP.
- RESP: cpu_ready = 1, cpu_err = 0 for exactly one cycle; mem_req = 0; return to IDLE.
- ERR: cpu_ready = 1, cpu_err = 1 for one cycle; mem_req = 0; cpu_data unchanged; return to IDLE.
- Counter: cleared on every entry to ISSUE; 8 bits wide; never wraps.
- cpu_data:
  - Updated only on a read acknowledged in ISSUE.
  - Holds its value across writes, errors and idle cycles.
- Latency:
  - Request strobed at edge k, zero-wait memory (mem_ack high on the first ISSUE cycle): cpu_ready is high in the cycle after edge k+2.
  - Each wait state adds one cycle.
  - Range error: cpu_ready/cpu_err are high in the cycle after edge k+1.
- Busy: cpu_req asserted outside IDLE is ignored (not queued). The core must wait for cpu_ready before issuing the next request.
- Spurious mem_ack in IDLE, RESP or ERR is ignored; no state or data change.
- In all states except ISSUE, mem_we, mem_addr and mem_wdata hold their last values; only mem_req is forced low.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with cpu_req = 1 and mem_ack = 1 -> all outputs 0; state IDLE; no mem_req.
- Zero-wait read: cpu_req, rw = 1, addr 0x10, memory acks immediately with 0xDEADBEEF -> mem_req high 1 cycle with mem_we = 0 and mem_addr = 0x10; cpu_ready pulses 2 cycles after the request; cpu_data = 0xDEADBEEF.
- Write with 3 wait states: rw = 0, addr 0x20, datao 0x1234_5678 -> mem_req high 4 cycles with mem_we = 1 and mem_wdata = 0x12345678; cpu_ready pulses once; cpu_err = 0; cpu_data unchanged.
- Timeout (TIMEOUT = 4, no ack) -> mem_req high exactly 4 cycles; then cpu_ready = cpu_err = 1 for one cycle; back in IDLE. Variant with ack on the 4th cycle -> normal completion, cpu_err = 0.
- Range error: read at 0x0001_0000 -> mem_req never asserts; cpu_ready = cpu_err = 1 one cycle after the request.
- Busy and abort:
  - Second cpu_req during ISSUE is ignored (only one bus transaction observed).
  - Spurious mem_ack in IDLE leaves cpu_data unchanged.
  - reset = 0 mid-ISSUE drops mem_req on the next cycle and no cpu_ready is produced.

Source files
------------

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge
// Turns single-cycle memory requests from the cpu core into a held,
// acknowledged transaction on the external memory bus. Adds wait-state
// tolerance, a per-transaction timeout and an address-range check, and
// reports completion to the core with a one-cycle ready/error pulse.
//
// Handshake: the core strobes cpu_req for one cycle while the bridge is idle
// and then waits for cpu_ready. The bridge holds mem_req high, with mem_we,
// mem_addr and mem_wdata stable, until mem_ack is sampled high at a clk
// edge or until TIMEOUT cycles have elapsed. mem_ack also qualifies
// mem_rdata on reads.
//
// Ports:
//   clk, reset          single clock, synchronous active-low reset
//   cpu_req/rw/address/datao   request from the core (rw: 1 = read)
//   cpu_data            read data returned to the core
//   cpu_ready, cpu_err  completion pulse, cpu_err marks a failed transaction
//   mem_req/we/addr/wdata      external bus request
//   mem_ack, mem_rdata  external bus acknowledge and read data
//   dbg_state           current FSM state, for observation only
module cpu_mem_bridge #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000,
  parameter int          TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_datao,
  output logic [31:0] cpu_data,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  // Counter value on the last permitted ISSUE cycle.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [1:0] next_state;
  logic [7:0] count;

  assign dbg_state = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          next_state = (cpu_address < ADDR_LIMIT) ? ISSUE : ERR;
        end
      end
      ISSUE: begin
        // Ack takes priority over timeout expiry on the same edge.
        if (mem_ack) begin
          next_state = RESP;
        end else if (count == LAST) begin
          next_state = ERR;
        end
      end
      RESP:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= 8'd0;
      cpu_data  <= 32'd0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      state   <= next_state;
      // mem_req is registered from the next state so it is high for exactly
      // the cycles spent in ISSUE.
      mem_req <= (next_state == ISSUE);
      // The completion pulse is registered from RESP/ERR, so it appears in
      // the cycle after those states.
      cpu_ready <= (state == RESP) || (state == ERR);
      cpu_err   <= (state == ERR);

      // The bus fields double as the request latch; they are loaded only
      // when a bus cycle starts so they hold their value everywhere else,
      // including on range errors.
      if (state == IDLE && next_state == ISSUE) begin
        mem_we    <= ~cpu_rw;
        mem_addr  <= cpu_address;
        mem_wdata <= cpu_datao;
        count     <= 8'd0;
      end else if (state == ISSUE && !mem_ack && count != LAST) begin
        count <= count + 8'd1;
      end

      if (state == ISSUE && mem_ack && !mem_we) begin
        cpu_data <= mem_rdata;
      end
    end
  end

endmodule
